ls_exec_unit: RTL and testbench
===============================

LS_EXEC_UNIT -- requirements
Module: ls_exec_unit

Interface
REQ-001 Parameter: ADDR_W, 32, effective/memory address width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 en_dec  in  1  decoded load/store op present this cycle.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 mode  in  2  access size: 00 null, 01 word, 10 halfword, 11 byte.
REQ-007 return_dout  in  1  1 = result is load data; 0 = result is effective address (update forms).
REQ-008 exts  in  1  sign-extend halfword load data.
REQ-009 do_request  in  1  1 = perform memory access; 0 = address-return-only cycle.
REQ-010 addr  in  ADDR_W  effective address, valid with en_dec.
REQ-011 sdata  in  32  store data, right-justified, valid with en_dec.
REQ-012 mem_req  out  1  memory request, held until acknowledged.
REQ-013 mem_we  out  1  memory write strobe, valid with mem_req.
REQ-014 mem_addr  out  ADDR_W  word-aligned address; bits [1:0] = 00.
REQ-015 mem_be  out  4  byte enables; be[3] = bits 31:24 = byte address 0 (big-endian).
REQ-016 mem_wdata  out  32  lane-aligned store data.
REQ-017 mem_ack  in  1  memory acknowledge; completes the request in the same cycle.
REQ-018 mem_rdata  in  32  read data, valid with mem_ack on loads.
REQ-019 result  out  32  load data or address, valid with result_valid.
REQ-020 result_valid  out  1  one-cycle pulse marking result.
REQ-021 busy  out  1  unit occupied; upstream holds en_dec low.
REQ-022 align_err  out  1  one-cycle pulse on misaligned access.

Function
REQ-023 FSM states: IDLE, REQ, DONE; state changes only on clk edges.
REQ-024 Accept when state = IDLE and en_dec = 1; input fields are captured into internal registers at acceptance.
REQ-025 Accepted op with mode = 00 is ignored: no request, no result, no error; state stays IDLE.
REQ-026 Misalignment rule: word with addr[1:0] != 00, or halfword with addr[0] = 1. A misaligned access with do_request = 1 pulses align_err the next cycle, issues no request and no result, and the state stays IDLE.
REQ-027 Accepted op with do_request = 0 goes IDLE -> DONE; result = addr; no memory access.
REQ-028 Accepted aligned op with do_request = 1 goes IDLE -> REQ; mem_req rises in the cycle after acceptance.
REQ-029 In REQ, mem_req, mem_we, mem_addr, mem_be and mem_wdata hold stable until the cycle mem_ack = 1; REQ -> DONE on that edge, and mem_req is low in the next cycle.
REQ-030 Byte enables: word = 1111; halfword = 1100 if addr[1] = 0, else 0011; byte = 1000 >> addr[1:0].
REQ-031 Store data is replicated into lanes: byte = {4{sdata[7:0]}}; halfword = {2{sdata[15:0]}}; word = sdata.
REQ-032 Load data is selected from the addressed lane and right-justified; upper bits are zero, except for halfword with exts = 1, which sign-extends bit 15. exts is ignored for byte and word.
REQ-033 Load data is registered on the mem_ack cycle.
REQ-034 DONE lasts exactly one cycle and then returns to IDLE.
REQ-035 In DONE, result_valid = 1 if we = 0 or return_dout = 0, else 0 (a plain store produces no result). result = load data if return_dout = 1 and we = 0, else the captured addr.
REQ-036 busy = 1 in REQ and DONE; busy = 0 in IDLE. Back-to-back acceptance is legal in the first IDLE cycle after DONE.
REQ-037 en_dec = 1 while busy = 1 is ignored and is a protocol error, flagged by a simulation-only assertion.
REQ-038 Latency with ack in the first request cycle: accept at cycle N, mem_req at N+1, result_valid at N+2.
REQ-039 When no result is being delivered, result holds its previous value.

Reset
REQ-040 On reset assertion, regardless of clk, the state goes to IDLE and mem_req, mem_we, mem_be, result_valid, busy and align_err go to 0; mem_addr, mem_wdata and result go to all zeros.
REQ-041 Reset during REQ drops mem_req immediately; a late mem_ack after reset is ignored.

Verification
REQ-042 Word load: addr = 0x104, ack one cycle after mem_req, rdata = 0xDEADBEEF -> mem_be = 1111, mem_addr = 0x104, result = 0xDEADBEEF, result_valid exactly 2 cycles after mem_req rose.
REQ-043 Halfword algebraic load: addr = 0x102, exts = 1, rdata = 0x1234_8001 -> mem_be = 0011, result = 0xFFFF8001; repeat with exts = 0 -> result = 0x00008001.
REQ-044 Byte store: addr = 0x203, sdata = 0xA5, ack delayed 3 cycles -> mem_be = 0001, mem_wdata = 0xA5A5A5A5, mem_req held 4 cycles, no result_valid.
REQ-045 Store-with-update: we = 1, return_dout = 0, addr = 0x300 -> result = 0x300 after ack. Load-update second cycle: do_request = 0 -> no mem_req, result = addr one cycle after acceptance.
REQ-046 Misaligned word: addr = 0x101 -> align_err pulses once, no mem_req, no result_valid.
REQ-047 Reset asserted mid-REQ -> mem_req and busy go to 0 without waiting for a clk edge; the next op then completes normally.

Source files
------------

// File: rtl/ls_exec_unit.sv
// Load/store execution unit: accepts one decoded memory op, drives a
// big-endian word-aligned request/ack bus, and returns load data or address.
module ls_exec_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_dec,
    input  logic              we,
    input  logic [1:0]        mode,
    input  logic              return_dout,
    input  logic              exts,
    input  logic              do_request,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       sdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       result,
    output logic              result_valid,
    output logic              busy,
    output logic              align_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [1:0] M_NULL = 2'b00;
    localparam logic [1:0] M_WORD = 2'b01;
    localparam logic [1:0] M_HALF = 2'b10;
    localparam logic [1:0] M_BYTE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic                rdout_q, rdout_d;
    logic                exts_q, exts_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;
    logic                align_err_q, align_err_d;

    logic                misaligned_c;
    logic                wants_result_c;

    // Byte enables; be[3] is byte address 0 (big-endian lane order).
    function automatic logic [BE_W-1:0] lane_be(input logic [1:0] m, input logic [1:0] off);
        logic [BE_W-1:0] be;
        case (m)
            M_WORD:  be = 4'b1111;
            M_HALF:  be = off[1] ? 4'b0011 : 4'b1100;
            M_BYTE:  be = 4'b1000 >> off;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [DATA_W-1:0] lane_wdata(input logic [1:0] m, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] w;
        case (m)
            M_HALF:  w = {2{d[15:0]}};
            M_BYTE:  w = {4{d[7:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed lane out of the read word and right-justify it.
    function automatic logic [DATA_W-1:0] lane_rdata(input logic [1:0] m, input logic [1:0] off,
                                                     input logic sx, input logic [DATA_W-1:0] rd);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        case (off)
            2'd0:    b = rd[31:24];
            2'd1:    b = rd[23:16];
            2'd2:    b = rd[15:8];
            default: b = rd[7:0];
        endcase
        h = off[1] ? rd[15:0] : rd[31:16];
        case (m)
            M_WORD:  r = rd;
            M_HALF:  r = {{16{sx & h[15]}}, h};
            M_BYTE:  r = {24'd0, b};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign misaligned_c = ((mode == M_WORD) && (addr[1:0] != 2'b00)) ||
                          ((mode == M_HALF) && addr[0]);
    assign wants_result_c = !we || !return_dout;

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        rdout_d        = rdout_q;
        exts_d         = exts_q;
        mode_d         = mode_q;
        addr_d         = addr_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_be_d       = mem_be_q;
        mem_wdata_d    = mem_wdata_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        align_err_d    = 1'b0;
        mem_req_d      = 1'b0;
        busy_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_dec) begin
                    we_d    = we;
                    rdout_d = return_dout;
                    exts_d  = exts;
                    mode_d  = mode;
                    addr_d  = addr;
                    if (mode == M_NULL) begin
                        state_d = S_IDLE;
                    end else if (!do_request) begin
                        state_d = S_DONE;
                        if (wants_result_c) begin
                            result_valid_d = 1'b1;
                            result_d       = DATA_W'(addr);
                        end
                    end else if (misaligned_c) begin
                        align_err_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        mem_we_d    = we;
                        mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = lane_be(mode, addr[1:0]);
                        mem_wdata_d = lane_wdata(mode, sdata);
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    if (!we_q || !rdout_q) begin
                        result_valid_d = 1'b1;
                        result_d       = (rdout_q && !we_q)
                                         ? lane_rdata(mode_q, addr_q[1:0], exts_q, mem_rdata)
                                         : DATA_W'(addr_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_req_d = (state_d == S_REQ);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            we_q           <= 1'b0;
            rdout_q        <= 1'b0;
            exts_q         <= 1'b0;
            mode_q         <= M_NULL;
            addr_q         <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= '0;
            mem_wdata_q    <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            align_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            rdout_q        <= rdout_d;
            exts_q         <= exts_d;
            mode_q         <= mode_d;
            addr_q         <= addr_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_be_q       <= mem_be_d;
            mem_wdata_q    <= mem_wdata_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            align_err_q    <= align_err_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign align_err    = align_err_q;

`ifndef SYNTHESIS
    // Upstream must hold en_dec low while the unit is occupied.
    assert property (@(posedge clk) disable iff (reset) !(en_dec && busy_q));
`endif

endmodule

// File: tb/tb_ls_exec_unit.sv
// Directed self-checking bench for ls_exec_unit with hand-computed expectations.
module tb_ls_exec_unit;

    logic        clk;
    logic        reset;
    logic        en_dec;
    logic        we;
    logic [1:0]  mode;
    logic        return_dout;
    logic        exts;
    logic        do_request;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic        align_err;

    int tests = 0;
    int fails = 0;

    ls_exec_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .en_dec       (en_dec),
        .we           (we),
        .mode         (mode),
        .return_dout  (return_dout),
        .exts         (exts),
        .do_request   (do_request),
        .addr         (addr),
        .sdata        (sdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .align_err    (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for a single acceptance edge.
    task automatic issue(input logic w, input logic [1:0] m, input logic rd, input logic sx,
                         input logic dr, input logic [31:0] a, input logic [31:0] sd);
        we = w; mode = m; return_dout = rd; exts = sx; do_request = dr; addr = a; sdata = sd;
        en_dec = 1'b1;
        tick();
        en_dec = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en_dec = 1'b0; we = 1'b0; mode = 2'b00; return_dout = 1'b0;
        exts = 1'b0; do_request = 1'b0; addr = '0; sdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rvalid", 32'(result_valid), 32'd0);
        chk("rst_align", 32'(align_err), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        tick();

        // Word load, ack one cycle after mem_req rises.
        issue(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 32'h104, 32'h0);
        chk("wl_req", 32'(mem_req), 32'd1);
        chk("wl_busy", 32'(busy), 32'd1);
        chk("wl_be", 32'(mem_be), 32'hF);
        chk("wl_maddr", mem_addr, 32'h104);
        chk("wl_mwe", 32'(mem_we), 32'd0);
        tick();
        chk("wl_req_hold", 32'(mem_req), 32'd1);
        chk("wl_rv_early", 32'(result_valid), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        chk("wl_rv", 32'(result_valid), 32'd1);
        chk("wl_result", result, 32'hDEADBEEF);
        chk("wl_req_drop", 32'(mem_req), 32'd0);
        chk("wl_busy_done", 32'(busy), 32'd1);
        tick();
        chk("wl_rv_pulse", 32'(result_valid), 32'd0);
        chk("wl_idle_busy", 32'(busy), 32'd0);
        chk("wl_result_hold", result, 32'hDEADBEEF);

        // Halfword algebraic load, ack in first request cycle (accept N, result N+2).
        issue(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 32'h102, 32'h0);
        chk("hs_be", 32'(mem_be), 32'h3);
        chk("hs_maddr", mem_addr, 32'h100);
        mem_ack = 1'b1; mem_rdata = 32'h12348001;
        tick();
        mem_ack = 1'b0;
        chk("hs_rv", 32'(result_valid), 32'd1);
        chk("hs_result", result, 32'hFFFF8001);
        tick();
        issue(1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0);
        chk("hz_be", 32'(mem_be), 32'h3);
        mem_ack = 1'b1; mem_rdata = 32'h12348001;
        tick();
        mem_ack = 1'b0;
        chk("hz_result", result, 32'h00008001);
        tick();

        // Byte store with ack delayed three cycles.
        issue(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 32'h203, 32'h000000A5);
        chk("bs_be", 32'(mem_be), 32'h1);
        chk("bs_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("bs_maddr", mem_addr, 32'h200);
        chk("bs_mwe", 32'(mem_we), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("bs_req_c%0d", i), 32'(mem_req), 32'd1);
        end
        chk("bs_wdata_stable", mem_wdata, 32'hA5A5A5A5);
        chk("bs_be_stable", 32'(mem_be), 32'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("bs_req_drop", 32'(mem_req), 32'd0);
        chk("bs_no_rv", 32'(result_valid), 32'd0);
        chk("bs_result_hold", result, 32'h00008001);
        chk("bs_busy_done", 32'(busy), 32'd1);
        tick();
        chk("bs_idle", 32'(busy), 32'd0);

        // Store with update returns the address.
        issue(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 32'h300, 32'h11223344);
        chk("su_wdata", mem_wdata, 32'h11223344);
        chk("su_maddr", mem_addr, 32'h300);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("su_rv", 32'(result_valid), 32'd1);
        chk("su_result", result, 32'h300);
        tick();

        // Address-return-only cycle: no memory access.
        issue(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h404, 32'h0);
        chk("ar_no_req", 32'(mem_req), 32'd0);
        chk("ar_rv", 32'(result_valid), 32'd1);
        chk("ar_result", result, 32'h404);
        chk("ar_busy", 32'(busy), 32'd1);
        tick();
        chk("ar_idle", 32'(busy), 32'd0);

        // Misaligned word.
        issue(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0);
        chk("ma_err", 32'(align_err), 32'd1);
        chk("ma_no_req", 32'(mem_req), 32'd0);
        chk("ma_no_rv", 32'(result_valid), 32'd0);
        chk("ma_busy", 32'(busy), 32'd0);
        tick();
        chk("ma_err_pulse", 32'(align_err), 32'd0);
        chk("ma_no_req2", 32'(mem_req), 32'd0);

        // Null mode is ignored.
        issue(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h555, 32'h0);
        chk("nm_busy", 32'(busy), 32'd0);
        chk("nm_no_rv", 32'(result_valid), 32'd0);
        chk("nm_result_hold", result, 32'h404);

        // Byte load from lane 1.
        issue(1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 32'h201, 32'h0);
        chk("bl_be", 32'(mem_be), 32'h4);
        mem_ack = 1'b1; mem_rdata = 32'h11AA2233;
        tick();
        mem_ack = 1'b0;
        chk("bl_result", result, 32'h000000AA);
        tick();

        // Asynchronous reset during REQ, then a late ack.
        issue(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 32'h108, 32'h0);
        chk("rr_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rr_req_async", 32'(mem_req), 32'd0);
        chk("rr_busy_async", 32'(busy), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        tick();
        reset = 1'b0;
        tick();
        mem_ack = 1'b0;
        chk("rr_late_ack_rv", 32'(result_valid), 32'd0);
        chk("rr_late_ack_busy", 32'(busy), 32'd0);
        chk("rr_late_ack_result", result, 32'd0);
        issue(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 32'h10C, 32'h0);
        chk("rr_next_req", 32'(mem_req), 32'd1);
        chk("rr_next_maddr", mem_addr, 32'h10C);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        chk("rr_next_rv", 32'(result_valid), 32'd1);
        chk("rr_next_result", result, 32'hCAFEF00D);
        tick();
        chk("rr_next_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
